ram_port_arb: RTL and testbench
===============================

# ram_port_arb

Round-robin arbiter that shares one synchronous RAM port (port A of the team's dual-port RAM wrapper) between up to 8 requesters. Each cycle it grants at most one read or write, drives a registered command onto the RAM port, and returns read data to the issuing requester with a tagged valid pulse. It holds off all grants while the RAM reports it is not ready, for example during a content clear.

## Interface
Parameters:
- G_NREQ, 4, number of requesters, 2..8
- G_ADDR, 10, RAM address width
- G_WIDTH, 16, RAM data width
- G_RDLAT, 1, RAM read latency in cycles from registered address to ram_rdat valid, 1..5

Ports (clock and reset first):
- clk  in  1  single clock for the arbiter and the RAM port
- rst_n  in  1  reset, asynchronous, active-low
- ramrdy  in  1  RAM ready; connect to the RAM clear-ready output; 0 blocks all grants
- req  in  G_NREQ  per-requester request level; held until ack; must not depend combinationally on ack
- wr  in  G_NREQ  per-requester direction: 1 = write, 0 = read
- addr  in  G_NREQ*G_ADDR  requester i at [i*G_ADDR +: G_ADDR]
- wdat  in  G_NREQ*G_WIDTH  requester i at [i*G_WIDTH +: G_WIDTH]
- ack  out  G_NREQ  one-hot, combinational grant; request consumed at the clock edge ending this cycle
- rvld  out  G_NREQ  one-hot, registered; read data valid for requester i
- rdat  out  G_WIDTH  registered shared read data; meaningful only when rvld != 0
- busy  out  1  registered; 1 while any read is outstanding
- ram_wen  out  1  registered RAM write enable
- ram_add  out  G_ADDR  registered RAM address
- ram_wdat  out  G_WIDTH  registered RAM write data
- ram_rdat  in  G_WIDTH  RAM read data

## Operation
- FSM states:
  - S_WAIT: entered on reset; ack = 0. Moves to S_RUN on the first cycle ramrdy = 1.
  - S_RUN: grants. Returns to S_WAIT in any cycle ramrdy = 0; no grant is issued in that cycle.
- Grant:
  - In S_RUN, ack selects the first requester with req = 1, searching upward from pointer ptr and wrapping modulo G_NREQ.
  - ptr (reset 0) becomes granted index + 1, wrapping G_NREQ-1 to 0. It is unchanged when nothing is granted.
- Command:
  - On a grant, at the next edge: ram_add <= addr[i], ram_wdat <= wdat[i], ram_wen <= wr[i].
  - Without a grant, ram_wen <= 0 and ram_add/ram_wdat hold their values.
- Read tracking:
  - A shift pipeline of depth G_RDLAT+1 carries {valid, index} for each granted read.
  - At the output stage: rvld[index] <= 1 and rdat <= ram_rdat.
  - rdat holds its value when no read completes.
- busy = OR of all pipeline valid bits.
- Outstanding reads always complete, including across ramrdy falling. Data returned during a clear is whatever the RAM returns.
- Access order is the grant order. Same-address write-then-read is resolved by the RAM write mode; the arbiter does not reorder.
- A requester may hold req high across consecutive acks to issue back-to-back accesses.

## Timing
- Reset values: ack 0, rvld 0, rdat 0, busy 0, ram_wen 0, ram_add 0, ram_wdat 0, ptr 0, state S_WAIT.
- Throughput: one access per cycle.
- Grant in cycle t:
  - RAM command is presented in cycle t+1.
  - Write lands at the edge ending t+1.
  - Read: ram_rdat is valid in cycle t+1+G_RDLAT; rvld/rdat are valid in cycle t+2+G_RDLAT.
  - Example, G_RDLAT = 1: ack cycle 0, rvld cycle 3.
- ramrdy = 0 in cycle t gives ack = 0 in cycle t. The first grant after recovery occurs in the first cycle after the cycle where ramrdy = 1 is seen in S_WAIT.
- Asynchronous reset mid-operation discards in-flight reads: no rvld is produced for them, and all outputs take their reset values immediately.

## Configuration
- RAM_ARB_PRIO_EN defined:
  - Requester 0 has strict priority: whenever req[0] = 1 and the FSM is in S_RUN, ack = 1 to requester 0 and ptr is unchanged.
  - Round-robin applies only among requesters 1..G_NREQ-1.
- RAM_ARB_PRIO_EN not defined: pure round-robin across all requesters, as described under Operation.

## Test plan
- Reset with req = 4'b1111 and ramrdy = 0 for 10 cycles -> ack = 0, ram_wen = 0, busy = 0. Raise ramrdy -> first grant ack = 4'b0001, then 0010, 0100, 1000, 0001 on consecutive cycles.
- Requester 2 writes 0xA5A5 to address 0x010, then reads 0x010 (G_RDLAT = 1) -> ram_wen = 1 with ram_add = 0x010 one cycle after the write ack; rvld = 4'b0100 with rdat = 0xA5A5 three cycles after the read ack.
- Requesters 0 and 3 each issue 3 back-to-back reads of distinct preloaded addresses -> strictly alternating acks; rvld tags and data match the issue order; busy falls 1 cycle after the last rvld.
- ramrdy drops for 5 cycles with 2 reads in flight -> both rvld pulses still occur; no ack and ram_wen = 0 while ramrdy = 0; granting resumes with ptr preserved.
- With RAM_ARB_PRIO_EN, req = 4'b0111 held -> ack = 4'b0001 every cycle. Drop req[0] -> ack alternates 0010/0100. Without the macro, the same stimulus -> 0001, 0010, 0100 rotation.
- Assert rst_n = 0 with a read in flight at G_RDLAT = 5 -> no rvld after reset release; all outputs are 0.

Source files
------------

// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin arbiter sharing one synchronous RAM port among
// G_NREQ requesters. Grants at most one access per cycle, registers the RAM
// command, and returns read data to the issuer with a tagged rvld pulse.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ramrdy          RAM ready; 0 blocks all grants
//   req, wr         per-requester request level and direction (1 = write)
//   addr, wdat      packed per-requester address / write data
//   ack             one-hot combinational grant
//   rvld, rdat      registered read-return tag and shared read data
//   busy            registered; 1 while any read is outstanding
//   ram_wen, ram_add, ram_wdat   registered RAM command
//   ram_rdat        RAM read data
//
// Optional feature: define RAM_ARB_PRIO_EN to give requester 0 strict
// priority; round-robin then applies only among requesters 1..G_NREQ-1.
module ram_port_arb #(
  parameter int unsigned G_NREQ  = 4,
  parameter int unsigned G_ADDR  = 10,
  parameter int unsigned G_WIDTH = 16,
  parameter int unsigned G_RDLAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ramrdy,
  input  logic [G_NREQ-1:0]         req,
  input  logic [G_NREQ-1:0]         wr,
  input  logic [G_NREQ*G_ADDR-1:0]  addr,
  input  logic [G_NREQ*G_WIDTH-1:0] wdat,
  output logic [G_NREQ-1:0]         ack,
  output logic [G_NREQ-1:0]         rvld,
  output logic [G_WIDTH-1:0]        rdat,
  output logic                      busy,
  output logic                      ram_wen,
  output logic [G_ADDR-1:0]         ram_add,
  output logic [G_WIDTH-1:0]        ram_wdat,
  input  logic [G_WIDTH-1:0]        ram_rdat
);

  localparam int unsigned IDX_W = (G_NREQ > 1) ? $clog2(G_NREQ) : 1;

  typedef enum logic [0:0] {S_WAIT, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               gnt;
  logic [G_NREQ-1:0]  rr_req;
  int                 j;

  // Read-return pipeline: stage k valid in cycle t+1+k for a grant in cycle t
  logic [G_RDLAT:0]   pipe_vld;
  logic [IDX_W-1:0]   pipe_idx [G_RDLAT+1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;
  end

  // Next state, grant selection and pointer update
  always_comb begin
    state_nxt = state;
    ack       = '0;
    gnt       = 1'b0;
    gnt_idx   = '0;
    ptr_nxt   = ptr;
    cand      = '0;
    j         = 0;
    rr_req    = req;
`ifdef RAM_ARB_PRIO_EN
    rr_req[0] = 1'b0;
`endif
    case (state)
      S_WAIT: begin
        if (ramrdy) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!ramrdy) begin
          state_nxt = S_WAIT;
        end else begin
`ifdef RAM_ARB_PRIO_EN
          // Requester 0 wins outright and leaves the pointer alone
          if (req[0]) begin
            gnt     = 1'b1;
            gnt_idx = '0;
          end
`endif
          for (int k = 0; k < int'(G_NREQ); k++) begin
            j = int'(ptr) + k;
            if (j >= int'(G_NREQ)) j = j - int'(G_NREQ);
            cand = IDX_W'(j);
            if (!gnt && rr_req[cand]) begin
              gnt     = 1'b1;
              gnt_idx = cand;
              ptr_nxt = (cand == IDX_W'(G_NREQ - 1)) ? '0 : cand + IDX_W'(1);
            end
          end
          if (gnt) ack = G_NREQ'(1) << gnt_idx;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // RAM command, read tracking and read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      ram_wen  <= 1'b0;
      ram_add  <= '0;
      ram_wdat <= '0;
      pipe_vld <= '0;
      for (int k = 0; k <= int'(G_RDLAT); k++) pipe_idx[k] <= '0;
      rvld     <= '0;
      rdat     <= '0;
      busy     <= 1'b0;
    end else begin
      ptr     <= ptr_nxt;
      ram_wen <= gnt & wr[gnt_idx];
      if (gnt) begin
        ram_add  <= addr[int'(gnt_idx)*int'(G_ADDR) +: G_ADDR];
        ram_wdat <= wdat[int'(gnt_idx)*int'(G_WIDTH) +: G_WIDTH];
      end
      pipe_vld    <= {pipe_vld[G_RDLAT-1:0], gnt & ~wr[gnt_idx]};
      pipe_idx[0] <= gnt_idx;
      for (int k = 1; k <= int'(G_RDLAT); k++) pipe_idx[k] <= pipe_idx[k-1];
      rvld <= pipe_vld[G_RDLAT] ? (G_NREQ'(1) << pipe_idx[G_RDLAT]) : '0;
      if (pipe_vld[G_RDLAT]) rdat <= ram_rdat;
      busy <= |pipe_vld;
    end
  end

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb: G_NREQ=4, G_RDLAT=1 main instance with a
// small RAM model, plus a G_RDLAT=5 instance for the reset-with-read-in-flight case.
module tb_ram_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ramrdy;
  logic [3:0]  req, wr;
  logic [9:0]  a_r [4];
  logic [15:0] d_r [4];
  logic [39:0] addr;
  logic [63:0] wdat;
  logic [3:0]  ack, rvld, ack5, rvld5;
  logic [15:0] rdat, rdat5, ram_wdat, ram_wdat5, ram_rdat;
  logic [9:0]  ram_add, ram_add5;
  logic        busy, busy5, ram_wen, ram_wen5;
  wire  [15:0] ram_rdat5 = 16'hBEEF;

  assign addr = {a_r[3], a_r[2], a_r[1], a_r[0]};
  assign wdat = {d_r[3], d_r[2], d_r[1], d_r[0]};

  always #5 clk = ~clk;

  ram_port_arb #(.G_NREQ(4), .G_ADDR(10), .G_WIDTH(16), .G_RDLAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .ramrdy(ramrdy), .req(req), .wr(wr),
    .addr(addr), .wdat(wdat), .ack(ack), .rvld(rvld), .rdat(rdat),
    .busy(busy), .ram_wen(ram_wen), .ram_add(ram_add), .ram_wdat(ram_wdat),
    .ram_rdat(ram_rdat));

  ram_port_arb #(.G_NREQ(4), .G_ADDR(10), .G_WIDTH(16), .G_RDLAT(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .ramrdy(ramrdy), .req(req), .wr(wr),
    .addr(addr), .wdat(wdat), .ack(ack5), .rvld(rvld5), .rdat(rdat5),
    .busy(busy5), .ram_wen(ram_wen5), .ram_add(ram_add5), .ram_wdat(ram_wdat5),
    .ram_rdat(ram_rdat5));

  // Background RAM content is a fixed pattern; one write slot overlays it
  function automatic logic [15:0] pat(input logic [9:0] a);
    return 16'h3C00 ^ {6'd0, a} ^ {a[5:0], 10'd0};
  endfunction

  logic        mw_vld;
  logic [9:0]  mw_a;
  logic [15:0] mw_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mw_vld <= 1'b0;
    else if (ram_wen) begin
      mw_vld <= 1'b1;
      mw_a   <= ram_add;
      mw_d   <= ram_wdat;
    end
  end
  always @(posedge clk) ram_rdat <= (mw_vld && mw_a == ram_add) ? mw_d : pat(ram_add);

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] dat;
    int          due;
  } exp_t;
  exp_t q[$];

  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic        last_busy;
  logic        ref_wv = 1'b0;
  logic [9:0]  ref_wa;
  logic [15:0] ref_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: inputs already driven; check ack and read returns at negedge
  task automatic cycle(input logic [3:0] exp_ack);
    int idx;
    exp_t e;
    @(negedge clk);
    cyc++;
    last_busy = busy;
    check("ack", 32'(ack), 32'(exp_ack));
    if (q.size() > 0 && q[0].due == cyc) begin
      check("rvld", 32'(rvld), 32'(q[0].tag));
      check("rdat", 32'(rdat), 32'(q[0].dat));
      void'(q.pop_front());
    end else begin
      check("rvld_idle", 32'(rvld), 32'd0);
    end
    if (exp_ack != 4'd0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (exp_ack[i]) idx = i;
      if (wr[idx]) begin
        ref_wv = 1'b1; ref_wa = a_r[idx]; ref_wd = d_r[idx];
      end else begin
        e.tag = exp_ack;
        e.dat = (ref_wv && ref_wa == a_r[idx]) ? ref_wd : pat(a_r[idx]);
        e.due = cyc + 3;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle(4'd0);
      n++;
    end
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ramrdy = 1'b0; req = 4'b1111; wr = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a_r[i] = 10'(10'h100 + i);
      d_r[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_rvld", 32'(rvld), 0);
    check("rst_rdat", 32'(rdat), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wen", 32'(ram_wen), 0);
    check("rst_add", 32'(ram_add), 0);
    check("rst_wdat", 32'(ram_wdat), 0);
    rst_n = 1'b1;

    // Not ready: nothing granted
    for (int i = 0; i < 10; i++) begin
      cycle(4'd0);
      check("nrdy_wen", 32'(ram_wen), 0);
      check("nrdy_busy", 32'(busy), 0);
    end
    ramrdy = 1'b1;
    cycle(4'd0);
    cycle(4'b0001); cycle(4'b0010); cycle(4'b0100); cycle(4'b1000); cycle(4'b0001);
    req = 4'd0;
    drain();

    // Requester 2: write then read back the same address
    req = 4'b0100; wr = 4'b0100; a_r[2] = 10'h010; d_r[2] = 16'hA5A5;
    cycle(4'b0100);
    req = 4'd0; wr = 4'd0;
    check("wr_wen", 32'(ram_wen), 1);
    check("wr_add", 32'(ram_add), 32'h010);
    check("wr_wdat", 32'(ram_wdat), 32'hA5A5);
    cycle(4'd0);
    req = 4'b0100;
    cycle(4'b0100);
    req = 4'd0;
    check("rd_wen", 32'(ram_wen), 0);
    drain();

    // Requesters 0 and 3: three back-to-back reads each
    begin
      int n0, n3;
      n0 = 0; n3 = 0;
      req = 4'b1001; a_r[0] = 10'h020; a_r[3] = 10'h030;
      for (int k = 0; k < 6; k++) begin
        if (k % 2 == 0) begin
          cycle(4'b1000);
          n3++; a_r[3] = a_r[3] + 10'd1;
          if (n3 == 3) req[3] = 1'b0;
        end else begin
          cycle(4'b0001);
          n0++; a_r[0] = a_r[0] + 10'd1;
          if (n0 == 3) req[0] = 1'b0;
        end
      end
    end
    drain();
    check("busy_at_last_rvld", 32'(last_busy), 1);
    check("busy_fall", 32'(busy), 0);

    // ramrdy drop with two reads in flight
    req = 4'b0110; a_r[1] = 10'h041; a_r[2] = 10'h042;
    cycle(4'b0010);
    cycle(4'b0100);
    req = 4'b1111; ramrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(4'd0);
      check("drop_wen", 32'(ram_wen), 0);
    end
    ramrdy = 1'b1;
    cycle(4'd0);
    cycle(4'b1000);
    req = 4'd0;

    // Priority vs. pure round-robin
    req = 4'b0111;
`ifdef RAM_ARB_PRIO_EN
    cycle(4'b0001); cycle(4'b0001); cycle(4'b0001); cycle(4'b0001);
`else
    cycle(4'b0001); cycle(4'b0010); cycle(4'b0100); cycle(4'b0001);
`endif
    req = 4'b0110;
    cycle(4'b0010); cycle(4'b0100); cycle(4'b0010);
    req = 4'd0;
    drain();

    // Asynchronous reset with a read in flight on the long-latency instance
    req = 4'b0001;
    cycle(4'b0001);
    req = 4'd0;
    cycle(4'd0);
    cycle(4'd0);
    check("busy5_inflight", 32'(busy5), 1);
    rst_n = 1'b0;
    #1;
    q.delete();
    ref_wv = 1'b0;
    check("arst_ack", 32'(ack), 0);
    check("arst_ram_add", 32'(ram_add), 0);
    check("arst_ram_wdat", 32'(ram_wdat), 0);
    check("arst_rdat", 32'(rdat), 0);
    check("arst_busy5", 32'(busy5), 0);
    check("arst_ack5", 32'(ack5), 0);
    check("arst_ram_add5", 32'(ram_add5), 0);
    check("arst_wen5", 32'(ram_wen5), 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(4'd0);
      check("post_rst_rvld5", 32'(rvld5), 0);
      check("post_rst_rdat5", 32'(rdat5), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
